// File: rtl/nibble_mul_pkg.sv
// rtl/nibble_mul_pkg.sv - shared widths and FSM encoding for the nibble-serial multiplier
package nibble_mul_pkg;

  localparam int A_W     = 16;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int B_W     = NIB_W * NUM_NIB;
  localparam int P_W     = A_W + B_W;
  localparam int PP_W    = A_W + NIB_W;
  localparam int CNT_W   = $clog2(NUM_NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pp16x4.sv
// rtl/pp16x4.sv - combinational 16x4 unsigned partial product, 20-bit result
module pp16x4
  import nibble_mul_pkg::*;
(
  input  logic [A_W-1:0]   a,
  input  logic [NIB_W-1:0] nib,
  output logic [PP_W-1:0]  pp
);

  assign pp = PP_W'(a) * PP_W'(nib);

endmodule

// File: rtl/nibble_mul_seq.sv
// rtl/nibble_mul_seq.sv - 16x16 multiply sequenced over one 16x4 unit, LS nibble first
// APPROX_LSN_SKIP_EN: approximate mode, lowest multiplier nibble treated as zero
module nibble_mul_seq
  import nibble_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] p,
  output logic           busy
);

  state_t             state_q, state_d;
  logic [A_W-1:0]     a_reg_q, a_reg_d;
  logic [B_W-1:0]     b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_W-1:0]     acc_q, acc_d;
  logic [P_W-1:0]     p_q, p_d;
  logic               out_valid_q, out_valid_d;
  logic [PP_W-1:0]    pp;
  logic [P_W-1:0]     acc_next;
  logic               last_nib;

  pp16x4 u_pp (
    .a   (a_reg_q),
    .nib (b_sh_q[NIB_W-1:0]),
    .pp  (pp)
  );

  assign acc_next = acc_q + (P_W'(pp) << (NIB_W * int'(cnt_q)));
  // Stop early once every nibble still waiting in b_sh is zero.
  assign last_nib = (cnt_q == CNT_W'(NUM_NIB - 1)) || ((b_sh_q >> NIB_W) == '0);

  always_comb begin
    state_d     = state_q;
    a_reg_d     = a_reg_q;
    b_sh_d      = b_sh_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_reg_d = a;
          acc_d   = '0;
`ifdef APPROX_LSN_SKIP_EN
          b_sh_d  = b >> NIB_W;
          cnt_d   = CNT_W'(1);
`else
          b_sh_d  = b;
          cnt_d   = '0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_next;
        b_sh_d = b_sh_q >> NIB_W;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_nib) begin
          p_d         = acc_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_reg_q     <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_reg_q     <= a_reg_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_nibble_mul_seq.sv
// tb/tb_nibble_mul_seq.sv - randomized self-checking bench for nibble_mul_seq
// APPROX_LSN_SKIP_EN: reference model follows the approximate mode when defined
module tb_nibble_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  function automatic logic [31:0] model_p(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] yy;
    yy = {16'b0, y};
`ifdef APPROX_LSN_SKIP_EN
    yy = yy & 32'h0000_FFF0;
`endif
    return {16'b0, x} * yy;
  endfunction

  function automatic int model_k(input logic [15:0] y);
    int hi = 0;
    for (int i = 0; i < 4; i++)
      if (((y >> (4 * i)) & 16'h000F) != 16'h0) hi = i;
`ifdef APPROX_LSN_SKIP_EN
    return (hi < 1) ? 1 : hi;
`else
    return hi + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL handshake_exclusive in_ready=%b out_valid=%b (must not both be 1)", in_ready, out_valid);
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input int stall,
                       output logic [31:0] got_p, output int lat, output logic seen);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = out_valid;
    got_p = p;
    for (int i = 0; i < stall; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0;
    b = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got out_valid=%b busy=%b in_ready=%b exp 0 0 0", out_valid, busy, in_ready);
    end
    checks++;
    if (p !== 32'h0) begin
      errors++;
      $display("FAIL reset_p got %h exp 00000000", p);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va[6];
    logic [15:0] vb[6];
    logic [31:0] vp[6];
    int          vk[6];
    int          nv;
    logic [31:0] got;
    int          lat;
    logic        seen;
`ifdef APPROX_LSN_SKIP_EN
    va[0] = 16'h0010; vb[0] = 16'h1234; vp[0] = 32'h0001_2300; vk[0] = 3;
    va[1] = 16'hFFFF; vb[1] = 16'h000F; vp[1] = 32'h0000_0000; vk[1] = 1;
    va[2] = 16'h0001; vb[2] = 16'h1000; vp[2] = 32'h0000_1000; vk[2] = 3;
    nv = 3;
`else
    va[0] = 16'hF003; vb[0] = 16'h000F; vp[0] = 32'h000E_102D; vk[0] = 1;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vp[1] = 32'hFFFE_0001; vk[1] = 4;
    va[2] = 16'hF003; vb[2] = 16'h000C; vp[2] = 32'h000B_4024; vk[2] = 1;
    va[3] = 16'h1234; vb[3] = 16'h0000; vp[3] = 32'h0000_0000; vk[3] = 1;
    va[4] = 16'h0001; vb[4] = 16'h1000; vp[4] = 32'h0000_1000; vk[4] = 4;
    nv = 5;
`endif
    for (int i = 0; i < nv; i++) begin
      issue(va[i], vb[i], 0, got, lat, seen);
      checks++;
      if (!seen || got !== vp[i]) begin
        errors++;
        $display("FAIL directed_p[%0d] got %h (seen=%b) exp %h", i, got, seen, vp[i]);
      end
      checks++;
      if (lat != vk[i] + 1) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, vk[i] + 1);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_handoff[%0d] got in_ready=%b out_valid=%b exp 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ta;
    logic [15:0] tbv;
    logic [31:0] held;
    logic [31:0] expv;
    int          n = 0;
    ta = 16'($urandom);
    tbv = 16'h0F37;
    expv = model_p(ta, tbv);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = p;
    checks++;
    if (out_valid !== 1'b1 || held !== expv) begin
      errors++;
      $display("FAIL bp_result got %h (valid=%b) exp %h", held, out_valid, expv);
    end
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (p !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got p=%h valid=%b in_ready=%b exp p=%h 1 0", i, p, out_valid, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int          lat;
    logic        seen;
    a = 16'hABCD;
    b = 16'hFFFF;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || p !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got out_valid=%b p=%h busy=%b in_ready=%b exp 0 00000000 0 0", out_valid, p, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    issue(16'h0002, 16'h0003, 0, got, lat, seen);
    checks++;
    if (!seen || got !== model_p(16'h0002, 16'h0003)) begin
      errors++;
      $display("FAIL midrst_next got %h (seen=%b) exp %h", got, seen, model_p(16'h0002, 16'h0003));
    end
  endtask

  task automatic test_random();
    logic [15:0] ta;
    logic [15:0] tbv;
    logic [31:0] got;
    int          lat;
    logic        seen;
    for (int i = 0; i < 40; i++) begin
      ta = 16'($urandom);
      tbv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) tbv = tbv & 16'hF0F0;
      issue(ta, tbv, $urandom_range(0, 2), got, lat, seen);
      checks++;
      if (!seen || got !== model_p(ta, tbv)) begin
        errors++;
        $display("FAIL rand_p a=%h b=%h got %h (seen=%b) exp %h", ta, tbv, got, seen, model_p(ta, tbv));
      end
      checks++;
      if (lat != model_k(tbv) + 1) begin
        errors++;
        $display("FAIL rand_latency b=%h got %0d exp %0d", tbv, lat, model_k(tbv) + 1);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_in_ready got %b exp 1", in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [31:0] expv;
    int          cyc = 0;
    int          prev = -1;
    int          pk = 0;
    int          done = 0;
    out_ready = 1'b1;
    a = 16'($urandom);
    b = 16'($urandom) >> (4 * $urandom_range(0, 3));
    in_valid = 1'b1;
    while (done < 6 && cyc < 300) begin
      if (out_valid) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious got out_valid=1 exp no pending operation");
        end else begin
          expv = model_p(qa.pop_front(), qb.pop_front());
          if (p !== expv) begin
            errors++;
            $display("FAIL b2b_p got %h exp %h", p, expv);
          end
        end
        done++;
        if (done >= 6) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != pk + 2) begin
            errors++;
            $display("FAIL b2b_interval got %0d exp %0d", cyc - prev, pk + 2);
          end
        end
        prev = cyc;
        pk = model_k(b);
        qa.push_back(a);
        qb.push_back(b);
        @(negedge clk);
        cyc++;
        a = 16'($urandom);
        b = 16'($urandom) >> (4 * $urandom_range(0, 3));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (done < 6) begin
      errors++;
      $display("FAIL b2b_timeout got %0d results exp 6", done);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_mul_seq.md
# nibble_mul_seq

Multi-cycle controller that computes a full 16x16 unsigned product by sequencing a single 16x4 partial-product unit over the nibbles of the multiplier, least-significant nibble first, with shift-and-accumulate. It sits between the DNN weight/activation feed and the accumulator stage. It gives one shared narrow multiplier full-width results, with data-dependent early termination and an optional approximate mode.

## Interface
- A_W, 16, multiplicand width.
- NIB_W, 4, multiplier slice width processed per cycle.
- NUM_NIB, 4, number of multiplier slices; B_W = NIB_W*NUM_NIB = 16.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; equals (state==IDLE) & ~rst.
- a  in  A_W  multiplicand, unsigned.
- b  in  B_W  multiplier, unsigned.
- out_valid  out  1  product valid; held until consumed.
- out_ready  in  1  consumer accepts product.
- p  out  A_W+B_W  product, unsigned, 32 bits.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: out_valid=0, p=0, busy=0, accumulator=0, nibble counter=0. in_ready=0 while rst is high and 1 in the first cycle after reset.
- IDLE: on in_valid & in_ready, latch a into a_reg and b into b_sh. Clear the accumulator and set cnt=0. Go to RUN.
- RUN, each cycle:
  - acc += pp(a_reg, b_sh[NIB_W-1:0]) << (NIB_W*cnt).
  - b_sh >>= NIB_W.
  - cnt++.
- Leave RUN for DONE when cnt reaches NUM_NIB-1 or when (b_sh >> NIB_W)==0, i.e. all remaining nibbles are zero (early termination).
- On entry to DONE: p <= final accumulated value; out_valid=1.
- DONE: hold p and out_valid stable while out_ready=0. On out_ready=1, deassert out_valid and go to IDLE.
- Arithmetic: acc is A_W+B_W bits wide. pp is A_W+NIB_W = 20 bits, zero-extended before the shift. No overflow is possible; the result is an exact unsigned product.
- in_valid outside IDLE is ignored and is not queued. a and b are sampled only on the accept edge.
- rst at any cycle, including mid-RUN or DONE, aborts the operation. Next cycle is IDLE with all outputs at reset values, and the in-flight result is discarded.

## Timing
- Accept edge E0. RUN edges E1..Ek, with k = 1 + index of the highest nonzero nibble of b; k=1 when b=0; 1 ≤ k ≤ 4.
- out_valid is high in the cycle after Ek. Latency from accept to out_valid = k+1 cycles.
- Handoff to the consumer:
  - If out_ready=1 while out_valid=1, the transfer occurs at that edge.
  - in_ready is high in the following cycle.
  - Minimum issue interval = k+2 cycles.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- APPROX_LSN_SKIP_EN defined:
  - The lowest multiplier nibble is forced to zero. At accept, b_sh <= b >> NIB_W, cnt starts at 1, and the product is a*(b & ~0xF).
  - Maximum k is 3. For b < 16, k=1 and p=0.
- Undefined: exact behaviour as above.

## Structure
- Shared package nibble_mul_pkg holds:
  - Constants A_W, NIB_W, NUM_NIB, P_W.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, pp16x4: combinational 16x4 unsigned partial product to 20 bits, instantiated once and fed from a_reg and b_sh[3:0].

## Test plan
- Reset, then a=0xF003, b=0x000F with out_ready=1 → p=0x000E102D. k=1; out_valid high 2 cycles after accept.
- a=0xFFFF, b=0xFFFF → p=0xFFFE0001, out_valid 5 cycles after accept. Then a=0xF003, b=0x000C → p=0x000B4024 after 2 cycles.
- b=0x0000, a=0x1234 → p=0 with k=1. Then a=0x0001, b=0x1000 → p=0x1000 with k=4.
- Backpressure: out_ready=0 for 3 cycles after out_valid → p held stable and in_ready=0. A new in_valid during this window is not accepted. After out_ready=1, in_ready rises the next cycle.
- Reset mid-operation: assert rst on the cycle after E2 with b=0xFFFF → the next cycle has state IDLE, out_valid=0, p=0 and busy=0. A subsequent transaction with a=0x0002, b=0x0003 gives p=0x6.
- With APPROX_LSN_SKIP_EN, a=0x0010, b=0x1234 → p=0x00012300 with k=3. With a=0xFFFF, b=0x000F → p=0 with k=1.
